// File: rtl/vip_bit_morph_3x3_if.sv
// Pixel-stream bundle shared by the Sobel edge stage and the morphology stage.
//   frame_vsync : frame sync, active high; its rising edge marks a new frame
//   frame_href  : line valid
//   frame_clken : pixel enable; a pixel moves only when href & clken are both 1
//   img_bit     : 1-bit edge pixel
// Modports:
//   master : the side that drives the stream
//   slave  : the side that consumes the stream
// Flow control: the stream has no ready/backpressure signal. A pixel is transferred
// in every cycle where frame_href and frame_clken are both high, and the consumer
// must take it in that cycle.
interface vip_bit_morph_3x3_if;
  logic frame_vsync;
  logic frame_href;
  logic frame_clken;
  logic img_bit;

  modport master (output frame_vsync, frame_href, frame_clken, img_bit);
  modport slave  (input  frame_vsync, frame_href, frame_clken, img_bit);
endinterface

// File: rtl/vip_bit_morph_3x3.sv
// 3x3 binary morphology (MODE 0 = dilate / OR of 9, MODE 1 = erode / AND of 9) on the
// 1-bit edge map coming out of the Sobel stage. Two internal 1-bit line buffers feed a
// 3x3 window; out-of-image taps are replaced by PAD (0 for dilate, 1 for erode).
// Ports:
//   clk          : pixel clock
//   rst          : synchronous reset, active high
//   per_frame    : input pixel stream (slave)
//   post_frame   : output pixel stream (master); sync signals are the input ones
//                  delayed 2 clk, img_bit is the morphology result (0 when href is 0)
//   line_overrun : sticky, set when a line in this frame exceeds IMG_WIDTH pixels;
//                  cleared on the next vsync rising edge
// Output pixel k of a line pairs with input pixel k, so the result is centred one
// pixel left and one line up from the pixel it is reported with.
module vip_bit_morph_3x3 #(
  parameter int IMG_WIDTH = 640,
  parameter bit MODE      = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  vip_bit_morph_3x3_if.slave  per_frame,
  vip_bit_morph_3x3_if.master post_frame,
  output logic                line_overrun
);

  localparam int            CW      = $clog2(IMG_WIDTH + 1);
  localparam int            AW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] COL_END = CW'(IMG_WIDTH);
  localparam logic [10:0]   ROW_SAT = 11'd2047;
  localparam logic          PAD     = MODE;

  logic                 vsync_d;
  logic                 href_d;
  logic                 vsync_rise;
  logic                 href_fall;
  logic                 accept;
  logic                 in_range;
  logic [CW-1:0]        col;
  logic [10:0]          row;
  logic [AW-1:0]        col_idx;
  logic [IMG_WIDTH-1:0] lb1;
  logic [IMG_WIDTH-1:0] lb2;
  logic                 lb1_rd;
  logic                 lb2_rd;
  // Window rows: top = two lines up (lb2), mid = previous line (lb1), bot = current.
  // Bit [2] is the newest column, bit [0] the oldest.
  logic [2:0]           win_top;
  logic [2:0]           win_mid;
  logic [2:0]           win_bot;
  logic                 pad_top;
  logic                 pad_mid;
  logic                 pad_c0;
  logic                 pad_c1;
  logic                 force_zero;
  logic                 acc_d1;
  logic [2:0]           col_pad;
  logic [8:0]           taps;
  logic [8:0]           pad9;
  logic [8:0]           eff;
  logic                 morph;
  logic                 bit_r;
  logic [1:0]           vsync_pipe;
  logic [1:0]           href_pipe;
  logic [1:0]           clken_pipe;

  assign vsync_rise = per_frame.frame_vsync & ~vsync_d;
  assign href_fall  = href_d & ~per_frame.frame_href;
  assign accept     = per_frame.frame_href & per_frame.frame_clken;
  assign in_range   = (col < COL_END);
  assign col_idx    = col[AW-1:0];

  // Buffer read; col == IMG_WIDTH is an overrun pixel and must not index the buffers.
  always_comb begin
    lb1_rd = 1'b0;
    lb2_rd = 1'b0;
    if (in_range) begin
      lb1_rd = lb1[col_idx];
      lb2_rd = lb2[col_idx];
    end
  end

  // Line buffers are never cleared; stale entries are hidden by the row-based pad mask.
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      lb2[col_idx] <= lb1_rd;
      lb1[col_idx] <= per_frame.img_bit;
    end
  end

  // Column/row position and overrun flag. Frame start beats every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d      <= 1'b0;
      href_d       <= 1'b0;
      col          <= '0;
      row          <= '0;
      line_overrun <= 1'b0;
    end else begin
      vsync_d <= per_frame.frame_vsync;
      href_d  <= per_frame.frame_href;
      if (vsync_rise) begin
        col          <= '0;
        row          <= '0;
        line_overrun <= 1'b0;
      end else begin
        if (href_fall) begin
          col <= '0;
          if (row != ROW_SAT) begin
            row <= row + 11'd1;
          end
        end else if (accept && in_range) begin
          col <= col + CW'(1);
        end
        if (accept && !in_range) begin
          line_overrun <= 1'b1;
        end
      end
    end
  end

  // Stage 1: shift the window and register which taps fall outside the image.
  // An overrun pixel leaves the window alone and only flags its output as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_top    <= '0;
      win_mid    <= '0;
      win_bot    <= '0;
      pad_top    <= 1'b0;
      pad_mid    <= 1'b0;
      pad_c0     <= 1'b0;
      pad_c1     <= 1'b0;
      force_zero <= 1'b0;
      acc_d1     <= 1'b0;
    end else begin
      acc_d1 <= accept;
      if (accept) begin
        force_zero <= ~in_range;
        if (in_range) begin
          win_top <= {lb2_rd, win_top[2:1]};
          win_mid <= {lb1_rd, win_mid[2:1]};
          win_bot <= {per_frame.img_bit, win_bot[2:1]};
          pad_top <= (row < 11'd2);
          pad_mid <= (row == 11'd0);
          pad_c0  <= (col < CW'(2));
          pad_c1  <= (col == '0);
        end
      end
    end
  end

  // Column pad covers the two older columns at the start of a line, which also hides
  // whatever the window still holds from the end of the previous line.
  always_comb begin
    col_pad = {1'b0, pad_c1, pad_c0};
    taps    = {win_top, win_mid, win_bot};
    pad9    = {col_pad | {3{pad_top}}, col_pad | {3{pad_mid}}, col_pad};
    eff     = PAD ? (taps | pad9) : (taps & ~pad9);
    morph   = PAD ? (&eff) : (|eff);
  end

  // Stage 2: result register plus the matching 2-deep sync delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_pipe <= '0;
      href_pipe  <= '0;
      clken_pipe <= '0;
      bit_r      <= 1'b0;
    end else begin
      vsync_pipe <= {vsync_pipe[0], per_frame.frame_vsync};
      href_pipe  <= {href_pipe[0], per_frame.frame_href};
      clken_pipe <= {clken_pipe[0], per_frame.frame_clken};
      bit_r      <= acc_d1 & ~force_zero & morph;
    end
  end

  assign post_frame.frame_vsync = vsync_pipe[1];
  assign post_frame.frame_href  = href_pipe[1];
  assign post_frame.frame_clken = clken_pipe[1];
  assign post_frame.img_bit     = bit_r;

endmodule

// File: tb/tb_vip_bit_morph_3x3.sv
// Bench for vip_bit_morph_3x3: a dilate instance and an erode instance, IMG_WIDTH = 8,
// fed from the same input stream. Directed frames with hand-computed result images.
// Row words below: bit c is column c of that output line.
module tb_vip_bit_morph_3x3;
  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vip_bit_morph_3x3_if in_if();
  vip_bit_morph_3x3_if out0_if();
  vip_bit_morph_3x3_if out1_if();
  logic ovr0;
  logic ovr1;

  vip_bit_morph_3x3 #(.IMG_WIDTH(W), .MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .per_frame(in_if), .post_frame(out0_if), .line_overrun(ovr0)
  );
  vip_bit_morph_3x3 #(.IMG_WIDTH(W), .MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .per_frame(in_if), .post_frame(out1_if), .line_overrun(ovr1)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         idle_bad     = 0;
  logic       cap0_q[$];
  logic       cap1_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] img  [4];
  logic [9:0] exp0 [4];
  logic [9:0] exp1 [4];
  logic [9:0] got0 [4];
  logic [9:0] got1 [4];
  logic [9:0] ref0 [4];
  logic [9:0] ref1 [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // driver: apply one cycle of input, return just after the sampling edge
  task automatic drive(input logic v, input logic h, input logic c, input logic b);
    in_if.frame_vsync = v;
    in_if.frame_href  = h;
    in_if.frame_clken = c;
    in_if.img_bit     = b;
    @(posedge clk);
    #1;
  endtask

  // one frame of img; toggle inserts a clken=0 cycle (random pixel) after every pixel
  task automatic send_frame(input int rows, input int cols, input bit toggle);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    cap0_q.delete();
    cap1_q.delete();
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        drive(1'b1, 1'b1, 1'b1, img[r][c]);
        if (toggle) drive(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      end
      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard: captured output pixels regrouped into lines against exp0/exp1
  task automatic check_frame(input string tag, input int rows, input int cols);
    logic [9:0] got;
    check($sformatf("%s dut0 count", tag), cap0_q.size(), rows * cols);
    check($sformatf("%s dut1 count", tag), cap1_q.size(), rows * cols);
    for (int r = 0; r < rows; r++) exp_q.push_back(exp0[r]);
    for (int r = 0; r < rows; r++) exp_q.push_back(exp1[r]);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < rows; r++) begin
        got = '0;
        for (int c = 0; c < cols; c++) begin
          if (d == 0 && cap0_q.size() > 0) got[c] = cap0_q.pop_front();
          if (d == 1 && cap1_q.size() > 0) got[c] = cap1_q.pop_front();
        end
        if (d == 0) got0[r] = got;
        else        got1[r] = got;
        check($sformatf("%s dut%0d row%0d", tag, d, r), got, exp_q.pop_front());
      end
    end
  endtask

  // latency stimulus {vsync, href, clken}; zero before the pattern starts
  function automatic logic [2:0] pat(input int i);
    logic v;
    logic h;
    logic c;
    if (i < 0) return 3'b000;
    v = (i >= 1 && i < 13);
    h = (i >= 3 && i < 8) || (i == 10);
    c = (i >= 3 && i < 8 && i != 5) || (i == 11);
    return {v, h, c};
  endfunction

  // monitor: collect valid output pixels, flag any 1 outside href
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_if.frame_href && out0_if.frame_clken) cap0_q.push_back(out0_if.img_bit);
      if (out1_if.frame_href && out1_if.frame_clken) cap1_q.push_back(out1_if.img_bit);
      if (!out0_if.frame_href && out0_if.img_bit) idle_bad++;
      if (!out1_if.frame_href && out1_if.img_bit) idle_bad++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500000, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0] p;
    logic [2:0] e;

    rst = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst post_vsync", out0_if.frame_vsync, 1'b0);
    check("rst post_href", out0_if.frame_href, 1'b0);
    check("rst post_clken", out1_if.frame_clken, 1'b0);
    check("rst post_bit", {out0_if.img_bit, out1_if.img_bit}, 2'b00);
    check("rst overrun", {ovr0, ovr1}, 2'b00);
    rst = 1'b0;

    // single 1 at (1,3): dilate gives rows 1..3, cols 3..5; erode gives nothing
    img  = '{10'h000, 10'h008, 10'h000, 10'h000};
    exp0 = '{10'h000, 10'h038, 10'h038, 10'h038};
    exp1 = '{10'h000, 10'h000, 10'h000, 10'h000};
    send_frame(4, W, 1'b0);
    check_frame("dot", 4, W);
    check("dot overrun", {ovr0, ovr1}, 2'b00);

    // all ones: padding keeps erode at 1 on the borders
    img  = '{10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF};
    exp0 = '{10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF};
    exp1 = '{10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF};
    send_frame(4, W, 1'b0);
    check_frame("ones", 4, W);

    // one hole at (1,3): erode clears rows 1..3, cols 3..5
    img  = '{10'h0FF, 10'h0F7, 10'h0FF, 10'h0FF};
    exp0 = '{10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF};
    exp1 = '{10'h0FF, 10'h0C7, 10'h0C7, 10'h0C7};
    send_frame(4, W, 1'b0);
    check_frame("hole", 4, W);

    // latency of the sync pipe and zero output outside href
    for (int i = 0; i < 16; i++) begin
      p = pat(i);
      in_if.frame_vsync = p[2];
      in_if.frame_href  = p[1];
      in_if.frame_clken = p[0];
      in_if.img_bit     = 1'b1;
      @(negedge clk);
      e = pat(i - 2);
      check($sformatf("lat%0d vsync", i), out0_if.frame_vsync, e[2]);
      check($sformatf("lat%0d href", i), out0_if.frame_href, e[1]);
      check($sformatf("lat%0d clken", i), out0_if.frame_clken, e[0]);
      check($sformatf("lat%0d dut1 sync", i),
            {out1_if.frame_vsync, out1_if.frame_href, out1_if.frame_clken}, e);
      if (!e[1]) check($sformatf("lat%0d idle bit", i), {out0_if.img_bit, out1_if.img_bit}, 2'b00);
      @(posedge clk);
      #1;
    end
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);

    // checkerboard, clken always 1, then clken toggling
    img  = '{10'h0AA, 10'h055, 10'h0AA, 10'h055};
    exp0 = '{10'h0FE, 10'h0FF, 10'h0FF, 10'h0FF};
    exp1 = '{10'h000, 10'h000, 10'h000, 10'h000};
    send_frame(4, W, 1'b0);
    check_frame("chk plain", 4, W);
    ref0 = got0;
    ref1 = got1;
    send_frame(4, W, 1'b1);
    check_frame("chk toggle", 4, W);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("toggle vs plain dut0 row%0d", r), got0[r], ref0[r]);
      check($sformatf("toggle vs plain dut1 row%0d", r), got1[r], ref1[r]);
    end

    // 10-pixel lines: pixels 8 and 9 forced to 0, overrun sticks past the frame
    img  = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    exp0 = '{10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF};
    exp1 = '{10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF};
    send_frame(4, 10, 1'b0);
    check_frame("overrun", 4, 10);
    check("overrun set", {ovr0, ovr1}, 2'b11);

    // next frame start clears it
    img  = '{10'h0FF, 10'h0FF, 10'h0FF, 10'h0FF};
    send_frame(4, W, 1'b0);
    check_frame("after overrun", 4, W);
    check("overrun cleared", {ovr0, ovr1}, 2'b00);

    // reset for one clock in the middle of a line with vsync high
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("pre-rst sync", {out0_if.frame_vsync, out0_if.frame_href, out0_if.frame_clken}, 3'b111);
    check("pre-rst bit", {out0_if.img_bit, out1_if.img_bit}, 2'b11);
    check("pre-rst overrun", {ovr0, ovr1}, 2'b11);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("mid-rst dut0 outs",
          {out0_if.frame_vsync, out0_if.frame_href, out0_if.frame_clken, out0_if.img_bit, ovr0}, 5'b0);
    check("mid-rst dut1 outs",
          {out1_if.frame_vsync, out1_if.frame_href, out1_if.frame_clken, out1_if.img_bit, ovr1}, 5'b0);
    rst = 1'b0;
    repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);

    img  = '{10'h000, 10'h008, 10'h000, 10'h000};
    exp0 = '{10'h000, 10'h038, 10'h038, 10'h038};
    exp1 = '{10'h000, 10'h000, 10'h000, 10'h000};
    send_frame(4, W, 1'b0);
    check_frame("after rst", 4, W);
    check("after rst overrun", {ovr0, ovr1}, 2'b00);

    check("idle bit zero", idle_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
